// File: rtl/l2req_arbiter_pkg.sv
// Shared definitions for the L2 request arbiter: field widths, unit IDs,
// L2 request opcodes, strand index width and the round-robin wrap helper.
// Imported by l2req_rr_select and l2req_arbiter.
package l2req_arbiter_pkg;

    // Strand index width of the core (4 hardware strands).
    localparam int STRAND_INDEX_WIDTH = 2;

    // Request field widths.
    localparam int UNIT_W = 2;
    localparam int OP_W   = 3;
    localparam int WAY_W  = 2;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 512;
    localparam int MASK_W = 64;
    localparam int PERF_W = 32;

    // Unit IDs carried in the unit field.
    localparam logic [UNIT_W-1:0] UNIT_ICACHE = 2'd0;
    localparam logic [UNIT_W-1:0] UNIT_DCACHE = 2'd1;
    localparam logic [UNIT_W-1:0] UNIT_STBUF  = 2'd2;
    localparam logic [UNIT_W-1:0] UNIT_IO     = 2'd3;

    // L2 request opcodes.
    localparam logic [OP_W-1:0] L2REQ_LOAD        = 3'd0;
    localparam logic [OP_W-1:0] L2REQ_STORE       = 3'd1;
    localparam logic [OP_W-1:0] L2REQ_FLUSH       = 3'd2;
    localparam logic [OP_W-1:0] L2REQ_IINVALIDATE = 3'd3;
    localparam logic [OP_W-1:0] L2REQ_DINVALIDATE = 3'd4;
    localparam logic [OP_W-1:0] L2REQ_LOAD_SYNC   = 3'd5;
    localparam logic [OP_W-1:0] L2REQ_STORE_SYNC  = 3'd6;

    // Requester index reached by stepping past the round-robin pointer,
    // wrapping modulo the number of requesters.
    function automatic int rr_wrap(input int idx, input int n);
        return idx % n;
    endfunction

endpackage

// File: rtl/l2req_rr_select.sv
// Rotating-priority grant: first valid requester after the pointer wins.
// Latency: purely combinational, no state.
// Backpressure: none here; the caller gates the grant with its load condition.
// Ports: req_valid_i (per-requester valid), ptr_i (last granted index),
//        grant_oh_o (one-hot or zero grant), grant_idx_o (index of grant),
//        grant_any_o (some requester was selected).
module l2req_rr_select
    import l2req_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int REQ_IDX_W = 2
) (
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [REQ_IDX_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   grant_oh_o,
    output logic [REQ_IDX_W-1:0] grant_idx_o,
    output logic                 grant_any_o
);

    int cand;

    // Scan ptr+1 .. ptr+NUM_REQ; the pointer itself is visited last, which
    // is what makes a just-granted requester lowest priority next time.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = rr_wrap(int'(ptr_i) + k, NUM_REQ);
            if (!grant_any_o && req_valid_i[cand]) begin
                grant_any_o      = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = REQ_IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/l2req_arbiter.sv
// Round-robin arbiter sharing the core's single L2 request port among NUM_REQ L1 requesters.
// Latency: 1 cycle from req accept to l2req_valid_o; full throughput, drain and fill in one cycle.
// Backpressure: l2req_ready_i low freezes the output register and pointer and drops all req_ready_o.
// Ports: clk_i/reset_i (sync, active-high); req_valid_i/req_ready_o plus flattened per-requester
//        fields req_{unit,strand,op,way,address,data,mask}_i (requester i at slice i);
//        l2req_valid_o/l2req_ready_i with registered l2req_* fields; perf_stall_cycles_o, perf_grants_o.
// Optional feature: define L2REQ_ARB_PERF_EN to build the performance counters; otherwise the
// perf outputs are tied to zero.
module l2req_arbiter
    import l2req_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int REQ_IDX_W = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    input  logic [NUM_REQ*UNIT_W-1:0]             req_unit_i,
    input  logic [NUM_REQ*STRAND_INDEX_WIDTH-1:0] req_strand_i,
    input  logic [NUM_REQ*OP_W-1:0]               req_op_i,
    input  logic [NUM_REQ*WAY_W-1:0]              req_way_i,
    input  logic [NUM_REQ*ADDR_W-1:0]             req_address_i,
    input  logic [NUM_REQ*DATA_W-1:0]             req_data_i,
    input  logic [NUM_REQ*MASK_W-1:0]             req_mask_i,
    output logic                                  l2req_valid_o,
    input  logic                                  l2req_ready_i,
    output logic [UNIT_W-1:0]                     l2req_unit_o,
    output logic [STRAND_INDEX_WIDTH-1:0]         l2req_strand_o,
    output logic [OP_W-1:0]                       l2req_op_o,
    output logic [WAY_W-1:0]                      l2req_way_o,
    output logic [ADDR_W-1:0]                     l2req_address_o,
    output logic [DATA_W-1:0]                     l2req_data_o,
    output logic [MASK_W-1:0]                     l2req_mask_o,
    output logic [PERF_W-1:0]                     perf_stall_cycles_o,
    output logic [NUM_REQ*PERF_W-1:0]             perf_grants_o
);

    logic                          load;
    logic                          accept;
    logic                          grant_any;
    logic [NUM_REQ-1:0]            grant_oh;
    logic [REQ_IDX_W-1:0]          grant_idx;

    logic [REQ_IDX_W-1:0]          ptr_q,    ptr_d;
    logic                          vld_q,    vld_d;
    logic [UNIT_W-1:0]             unit_q,   unit_d;
    logic [STRAND_INDEX_WIDTH-1:0] strand_q, strand_d;
    logic [OP_W-1:0]               op_q,     op_d;
    logic [WAY_W-1:0]              way_q,    way_d;
    logic [ADDR_W-1:0]             addr_q,   addr_d;
    logic [DATA_W-1:0]             data_q,   data_d;
    logic [MASK_W-1:0]             mask_q,   mask_d;

    l2req_rr_select #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_rr_select (
        .req_valid_i (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // The output slot can take a new entry when it is empty or is being
    // drained this very cycle, so a steady stream never bubbles.
    assign load        = !vld_q || l2req_ready_i;
    assign accept      = load && grant_any;
    assign req_ready_o = load ? grant_oh : '0;

    always_comb begin
        ptr_d    = ptr_q;
        vld_d    = vld_q;
        unit_d   = unit_q;
        strand_d = strand_q;
        op_d     = op_q;
        way_d    = way_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        if (load) begin
            // With nothing to send the slot empties but keeps its stale fields.
            vld_d = grant_any;
            if (grant_any) begin
                ptr_d    = grant_idx;
                unit_d   = req_unit_i[grant_idx*UNIT_W +: UNIT_W];
                strand_d = req_strand_i[grant_idx*STRAND_INDEX_WIDTH +: STRAND_INDEX_WIDTH];
                op_d     = req_op_i[grant_idx*OP_W +: OP_W];
                way_d    = req_way_i[grant_idx*WAY_W +: WAY_W];
                addr_d   = req_address_i[grant_idx*ADDR_W +: ADDR_W];
                data_d   = req_data_i[grant_idx*DATA_W +: DATA_W];
                mask_d   = req_mask_i[grant_idx*MASK_W +: MASK_W];
            end
        end
    end

    // Pointer resets to the last index so requester 0 has first priority.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q    <= REQ_IDX_W'(NUM_REQ - 1);
            vld_q    <= 1'b0;
            unit_q   <= '0;
            strand_q <= '0;
            op_q     <= '0;
            way_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            vld_q    <= vld_d;
            unit_q   <= unit_d;
            strand_q <= strand_d;
            op_q     <= op_d;
            way_q    <= way_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
        end
    end

    assign l2req_valid_o   = vld_q;
    assign l2req_unit_o    = unit_q;
    assign l2req_strand_o  = strand_q;
    assign l2req_op_o      = op_q;
    assign l2req_way_o     = way_q;
    assign l2req_address_o = addr_q;
    assign l2req_data_o    = data_q;
    assign l2req_mask_o    = mask_q;

`ifdef L2REQ_ARB_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] grant_cnt_q [NUM_REQ];

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            if (vld_q && !l2req_ready_i) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && grant_oh[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + PERF_W'(1);
                end
            end
        end
    end

    assign perf_stall_cycles_o = stall_cnt_q;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_grants
        assign perf_grants_o[g*PERF_W +: PERF_W] = grant_cnt_q[g];
    end
`else
    assign perf_stall_cycles_o = '0;
    assign perf_grants_o       = '0;
`endif

`ifndef SYNTHESIS
    // Requesters still waiting for an accept at the end of each cycle.
    logic [NUM_REQ-1:0] pend_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= req_valid_i & ~req_ready_o;
        end
    end

    a_no_retract: assert property (@(posedge clk_i)
        reset_i || ((pend_q & ~req_valid_i) == '0));
    a_ready_onehot0: assert property (@(posedge clk_i)
        reset_i || $onehot0(req_ready_o));
    a_ready_needs_valid: assert property (@(posedge clk_i)
        reset_i || ((req_ready_o & ~req_valid_i) == '0));
`endif

endmodule

// File: tb/tb_l2req_arbiter.sv
module tb_l2req_arbiter;
    import l2req_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int SW = STRAND_INDEX_WIDTH;
`ifdef L2REQ_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N*2-1:0]    req_unit_i = '0;
    logic [N*SW-1:0]   req_strand_i = '0;
    logic [N*3-1:0]    req_op_i = '0;
    logic [N*2-1:0]    req_way_i = '0;
    logic [N*26-1:0]   req_address_i = '0;
    logic [N*512-1:0]  req_data_i = '0;
    logic [N*64-1:0]   req_mask_i = '0;
    logic              l2req_valid_o;
    logic              l2req_ready_i = 1'b0;
    logic [1:0]        l2req_unit_o;
    logic [SW-1:0]     l2req_strand_o;
    logic [2:0]        l2req_op_o;
    logic [1:0]        l2req_way_o;
    logic [25:0]       l2req_address_o;
    logic [511:0]      l2req_data_o;
    logic [63:0]       l2req_mask_o;
    logic [31:0]       perf_stall_cycles_o;
    logic [N*32-1:0]   perf_grants_o;

    l2req_arbiter #(.NUM_REQ(N), .REQ_IDX_W(2)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_unit_i          (req_unit_i),
        .req_strand_i        (req_strand_i),
        .req_op_i            (req_op_i),
        .req_way_i           (req_way_i),
        .req_address_i       (req_address_i),
        .req_data_i          (req_data_i),
        .req_mask_i          (req_mask_i),
        .l2req_valid_o       (l2req_valid_o),
        .l2req_ready_i       (l2req_ready_i),
        .l2req_unit_o        (l2req_unit_o),
        .l2req_strand_o      (l2req_strand_o),
        .l2req_op_o          (l2req_op_o),
        .l2req_way_o         (l2req_way_o),
        .l2req_address_o     (l2req_address_o),
        .l2req_data_o        (l2req_data_o),
        .l2req_mask_o        (l2req_mask_o),
        .perf_stall_cycles_o (perf_stall_cycles_o),
        .perf_grants_o       (perf_grants_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]    unit_f;
        logic [SW-1:0] strand_f;
        logic [2:0]    op_f;
        logic [1:0]    way_f;
        logic [25:0]   addr_f;
        logic [511:0]  data_f;
        logic [63:0]   mask_f;
    } txn_t;

    typedef struct {
        logic [N-1:0]  rdy;
        logic          vld;
        logic [31:0]   stall;
        logic [N*32-1:0] grants;
    } cyc_t;

    // Requester-side state: fields each requester currently presents.
    logic [1:0]    r_unit   [N];
    logic [SW-1:0] r_strand [N];
    logic [2:0]    r_op     [N];
    logic [1:0]    r_way    [N];
    logic [25:0]   r_addr   [N];
    logic [511:0]  r_data   [N];
    logic [63:0]   r_mask   [N];
    logic [N-1:0]  hold   = '0;   // presenting and not yet accepted
    logic [N-1:0]  preset = '0;   // fields set by a directed test

    // Reference model: last granted requester, output-slot occupancy, counters.
    int              m_ptr = N - 1;
    bit              m_out_valid = 1'b0;
    logic [31:0]     m_stall = '0;
    logic [N*32-1:0] m_grants = '0;

    txn_t exp_q[$];
    cyc_t cyc_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic rand_fields(input int i);
        r_unit[i]   = 2'($urandom_range(0, 3));
        r_strand[i] = SW'($urandom);
        r_op[i]     = 3'($urandom_range(0, 6));
        r_way[i]    = 2'($urandom);
        r_addr[i]   = 26'($urandom);
        for (int w = 0; w < 16; w++) r_data[i][w*32 +: 32] = $urandom;
        r_mask[i]   = {$urandom, $urandom};
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]              = hold[i];
            req_unit_i[i*2 +: 2]        = r_unit[i];
            req_strand_i[i*SW +: SW]    = r_strand[i];
            req_op_i[i*3 +: 3]          = r_op[i];
            req_way_i[i*2 +: 2]         = r_way[i];
            req_address_i[i*26 +: 26]   = r_addr[i];
            req_data_i[i*512 +: 512]    = r_data[i];
            req_mask_i[i*64 +: 64]      = r_mask[i];
        end
    endtask

    // One clock of stimulus: requesters in 'want' that are idle raise a new
    // request; waiting requesters keep theirs. The model then decides this
    // cycle's winner from the round-robin rule and queues expectations.
    task automatic step(input logic [N-1:0] want, input logic rdy);
        cyc_t e;
        txn_t t;
        bit   load;
        int   win;
        int   j;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && want[i]) begin
                if (!preset[i]) rand_fields(i);
                preset[i] = 1'b0;
                hold[i]   = 1'b1;
            end
        end
        drive();
        l2req_ready_i = rdy;

        e.vld    = m_out_valid;
        e.stall  = m_stall;
        e.grants = m_grants;
        e.rdy    = '0;
        load = !m_out_valid || rdy;
        win  = -1;
        if (load) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (win < 0 && hold[j]) win = j;
            end
        end
        if (PERF && m_out_valid && !rdy) m_stall = m_stall + 1;
        if (win >= 0) begin
            e.rdy[win] = 1'b1;
            t.unit_f   = r_unit[win];
            t.strand_f = r_strand[win];
            t.op_f     = r_op[win];
            t.way_f    = r_way[win];
            t.addr_f   = r_addr[win];
            t.data_f   = r_data[win];
            t.mask_f   = r_mask[win];
            exp_q.push_back(t);
            m_ptr       = win;
            m_out_valid = 1'b1;
            hold[win]   = 1'b0;
            if (PERF) m_grants[win*32 +: 32] = m_grants[win*32 +: 32] + 1;
        end else if (load) begin
            m_out_valid = 1'b0;
        end
        cyc_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        reset_i       = 1'b1;
        hold          = '0;
        preset        = '0;
        l2req_ready_i = 1'b0;
        drive();
        m_ptr = N - 1; m_out_valid = 1'b0; m_stall = '0; m_grants = '0;
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_next_valid", l2req_valid_o, 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid", l2req_valid_o, 0);
        chk("rst_fields", {l2req_unit_o, l2req_strand_o, l2req_op_o, l2req_way_o, l2req_address_o}, 0);
        chk("rst_data", l2req_data_o, 0);
        chk("rst_mask", l2req_mask_o, 0);
        chk("rst_perf", {perf_stall_cycles_o, perf_grants_o}, 0);
    endtask

    // Monitor: per-cycle expectations and transfers leaving on the L2 side.
    cyc_t mon_e;
    txn_t mon_t;
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                chk("req_ready", req_ready_o, mon_e.rdy);
                chk("l2req_valid", l2req_valid_o, mon_e.vld);
                chk("perf_stall", perf_stall_cycles_o, mon_e.stall);
                chk("perf_grants", perf_grants_o, mon_e.grants);
            end
            if (l2req_valid_o && l2req_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    chk("xfer_unit", l2req_unit_o, mon_t.unit_f);
                    chk("xfer_strand", l2req_strand_o, mon_t.strand_f);
                    chk("xfer_op", l2req_op_o, mon_t.op_f);
                    chk("xfer_way", l2req_way_o, mon_t.way_f);
                    chk("xfer_addr", l2req_address_o, mon_t.addr_f);
                    chk("xfer_data", l2req_data_o, mon_t.data_f);
                    chk("xfer_mask", l2req_mask_o, mon_t.mask_f);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [25:0]  a1;
        logic [1:0]   u1;
        logic [511:0] pat;
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) rand_fields(i);

        // 1: all valid, always ready -> grants 0,1,2,0,1,2
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(3'b111, 1'b1);
            @(negedge clk_i);
            oh = '0;
            oh[c % N] = 1'b1;
            chk("t1_grant", req_ready_o, oh);
            chk("t1_valid", l2req_valid_o, (c >= 1) ? 1 : 0);
        end

        // 2: stall with requester 2 in the output slot
        do_reset();
        r_addr[2] = 26'h0001234;
        preset[2] = 1'b1;
        step(3'b100, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(3'b001, 1'b0);
            @(negedge clk_i);
            chk("t2_addr", l2req_address_o, 26'h0001234);
            chk("t2_ready", req_ready_o, 0);
            chk("t2_valid", l2req_valid_o, 1);
        end
        step(3'b000, 1'b1);
        @(negedge clk_i);
        chk("t2_stall_cnt", perf_stall_cycles_o, PERF ? 5 : 0);

        // 3: drain and fill in the same cycle, then hold of stale fields
        do_reset();
        step(3'b001, 1'b1);
        step(3'b010, 1'b1);
        a1 = r_addr[1];
        u1 = r_unit[1];
        @(negedge clk_i);
        chk("t3_ready1", req_ready_o, 3'b010);
        chk("t3_drain_valid", l2req_valid_o, 1);
        step(3'b000, 1'b1);
        @(negedge clk_i);
        chk("t3_no_bubble", l2req_valid_o, 1);
        chk("t3_addr", l2req_address_o, a1);
        chk("t3_unit", l2req_unit_o, u1);
        step(3'b000, 1'b1);
        @(negedge clk_i);
        chk("t3_empty", l2req_valid_o, 0);
        chk("t3_hold_addr", l2req_address_o, a1);

        // 4: lone requester 1 back-to-back, then requester 0 joins
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(3'b010, 1'b1);
            @(negedge clk_i);
            chk("t4_grant1", req_ready_o, 3'b010);
        end
        step(3'b011, 1'b1);
        @(negedge clk_i);
        chk("t4_join0", req_ready_o, 3'b001);

        // 5: reset while stalled with a valid output
        do_reset();
        step(3'b100, 1'b1);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        do_reset();
        step(3'b111, 1'b1);
        @(negedge clk_i);
        chk("t5_first_grant", req_ready_o, 3'b001);

        // 6: store-buffer mask/data pass-through
        do_reset();
        for (int w = 0; w < 16; w++) pat[w*32 +: 32] = 32'hA5C3_0000 | 32'(w * 17);
        r_mask[2] = 64'hFFFF_0000_0000_00FF;
        r_data[2] = pat;
        preset[2] = 1'b1;
        step(3'b100, 1'b1);
        step(3'b000, 1'b1);
        @(negedge clk_i);
        chk("t6_mask", l2req_mask_o, 64'hFFFF_0000_0000_00FF);
        chk("t6_data", l2req_data_o, pat);

        // Random traffic against the model
        do_reset();
        repeat (3000) step(3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
        repeat (6) step(3'b000, 1'b1);
        @(negedge clk_i);
        #1;
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_hold", hold, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
